// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_fs_cell.sv
// One-bit full adder / full subtractor used by the serial datapath.
module fa_fs_cell
    import serial_add_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    always_comb begin
        s = a ^ b ^ cin;
        if (mode == MODE_SUB) begin
            // cin/cout carry the borrow in subtract mode
            cout = (~a & b) | (~(a ^ b) & cin);
        end else begin
            cout = (a & b) | (cin & (a ^ b));
        end
    end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: LSB-first through a single 1-bit cell, WIDTH cycles per operation.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-2:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic               sum_d;
    logic               carry_d;
    logic [WIDTH-1:0]   acc_d;
    logic               last_bit;

    fa_fs_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .mode (mode_q),
        .s    (sum_d),
        .cout (carry_d)
    );

    // Partial sum lives in acc_q; the final bit joins it only when the result is latched.
    always_comb begin
        acc_d    = {sum_d, acc_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    acc_q   <= acc_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        result_q <= acc_d;
                        cout_q   <= carry_d;
                        ovf_q    <= carry_q ^ carry_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: 8-bit directed vectors and a 4-bit exhaustive sweep.
module tb_serial_add_sub;
    import serial_add_sub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st8, m8, busy8, done8, c8, o8;
    logic [7:0] a8, b8, r8;
    logic       st4, m4, busy4, done4, c4, o4;
    logic [3:0] a4, b4, r4;

    serial_add_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .mode(m8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(r8), .cout(c8), .ovf(o8)
    );

    serial_add_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .mode(m4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(r4), .cout(c4), .ovf(o4)
    );

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
    } exp_t;

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   dones8 = 0;
    int   dones4 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Independent reference: integer arithmetic with signed range check for overflow.
    function automatic exp_t model(input int w, input logic m, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   mask, ai, bi, r, as, bs, sr;
        mask = (1 << w) - 1;
        ai   = int'(a) & mask;
        bi   = int'(b) & mask;
        if (m == MODE_ADD) begin
            r    = ai + bi;
            e.co = (r > mask);
        end else begin
            r    = ai - bi;
            e.co = (ai < bi);
        end
        e.res = 8'(r & mask);
        as    = (ai >= (1 << (w - 1))) ? ai - (1 << w) : ai;
        bs    = (bi >= (1 << (w - 1))) ? bi - (1 << w) : bi;
        sr    = (m == MODE_ADD) ? as + bs : as - bs;
        e.ov  = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
        return e;
    endfunction

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            dones8++;
            if (q8.size() == 0) begin
                chk("spurious_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("result8", r8, e.res);
                chk("cout8", c8, e.co);
                chk("ovf8", o8, e.ov);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rst_n === 1'b1 && done4 === 1'b1) begin
            dones4++;
            if (q4.size() == 0) begin
                chk("spurious_done4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("result4", r4, e.res);
                chk("cout4", c4, e.co);
                chk("ovf4", o4, e.ov);
            end
        end
    end

    // One 8-bit operation: operands scrambled during SHIFT, latency and output stability checked.
    task automatic run8(input vec_t v);
        exp_t       e;
        logic [7:0] prev;
        int         n;
        bit         got;
        @(posedge clk); #1;
        st8 = 1'b1; m8 = v.m; a8 = v.a; b8 = v.b;
        e.res = v.res; e.co = v.co; e.ov = v.ov;
        q8.push_back(e);
        prev = r8;
        @(posedge clk); #1;
        st8 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                got = 1'b1;
            end else begin
                if (n == 0) chk("busy_in_shift", busy8, 1);
                if (n == 3) chk("result_stable_in_shift", r8, prev);
                @(posedge clk); #1;
                n++;
                a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            end
        end
        chk("latency8", n, 8);
        @(posedge clk); #1;
        chk("done_one_cycle", done8, 0);
        chk("busy_after_done", busy8, 0);
    endtask

    task automatic run4(input logic m, input logic [3:0] a, input logic [3:0] b);
        int n;
        bit got;
        @(posedge clk); #1;
        st4 = 1'b1; m4 = m; a4 = a; b4 = b;
        q4.push_back(model(4, m, {4'h0, a}, {4'h0, b}));
        @(posedge clk); #1;
        st4 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (done4 === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("latency4", n, 4);
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t tbl[9];
        int   d0, n;
        tbl[0] = '{m: 1'b0, a: 8'hFF, b: 8'h01, res: 8'h00, co: 1'b1, ov: 1'b0};
        tbl[1] = '{m: 1'b1, a: 8'h05, b: 8'h07, res: 8'hFE, co: 1'b1, ov: 1'b0};
        tbl[2] = '{m: 1'b0, a: 8'h7F, b: 8'h01, res: 8'h80, co: 1'b0, ov: 1'b1};
        tbl[3] = '{m: 1'b1, a: 8'h10, b: 8'h01, res: 8'h0F, co: 1'b0, ov: 1'b0};
        tbl[4] = '{m: 1'b1, a: 8'h80, b: 8'h01, res: 8'h7F, co: 1'b0, ov: 1'b1};
        tbl[5] = '{m: 1'b0, a: 8'h80, b: 8'h80, res: 8'h00, co: 1'b1, ov: 1'b1};
        tbl[6] = '{m: 1'b1, a: 8'h00, b: 8'h00, res: 8'h00, co: 1'b0, ov: 1'b0};
        tbl[7] = '{m: 1'b1, a: 8'h7F, b: 8'hFF, res: 8'h80, co: 1'b1, ov: 1'b1};
        tbl[8] = '{m: 1'b0, a: 8'hAA, b: 8'h55, res: 8'hFF, co: 1'b0, ov: 1'b0};

        rst_n = 1'b0;
        st8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
        st4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_result8", r8, 0);
        chk("rst_cout8", c8, 0);
        chk("rst_ovf8", o8, 0);
        chk("rst_result4", r4, 0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run8(tbl[i]);

        // Start held high with operands changing every cycle: only the first capture counts.
        @(posedge clk); #1;
        st8 = 1'b1; m8 = MODE_ADD; a8 = 8'h3C; b8 = 8'h0F;
        q8.push_back(model(8, MODE_ADD, 8'h3C, 8'h0F));
        d0 = dones8;
        @(posedge clk); #1;
        n = 0;
        while (n < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            @(negedge clk);
            if (done8 === 1'b1) begin
                st8 = 1'b0;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("held_start_latency", n, 8);
        st8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("held_start_one_done", dones8 - d0, 1);

        // Reset while bit 3 is being processed aborts without a done pulse.
        @(posedge clk); #1;
        st8 = 1'b1; m8 = MODE_ADD; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        d0 = dones8;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_result", r8, 0);
        chk("abort_cout", c8, 0);
        chk("abort_ovf", o8, 0);
        #14;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", dones8 - d0, 0);
        chk("abort_idle", busy8, 0);
        run8(tbl[3]);

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(1'(m), 4'(a), 4'(b));

        repeat (4) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("dones4_total", dones4, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
